hub_slot_scheduler: RTL and testbench
=====================================

# hub_slot_scheduler

Time-slot scheduler that shares the single hub access port among the cogs of the p1v core. Runs in the `clock_160` domain. Generates the two-phase hub cycle, rotates slot ownership among cogs, and issues one-hot access grants to requesting cogs. Two rotation modes are available:
- **Propeller-compatible:** every cog owns a slot in turn.
- **Skip-idle:** slots of stopped cogs are skipped to cut hub latency.

## Interface
Parameters:
- `NUMCOGS`, 8, number of cogs sharing the hub; legal range 1–8, need not be a power of two.
- `SKIP_IDLE`, 0, 0 = fixed round-robin over all cogs; 1 = skip slots whose cog is not enabled.

Ports:
- `clock_160`  in  1  system clock.
- `inp_resn`  in  1  reset; asynchronous assert, active-low.
- `cog_ena`  in  NUMCOGS  bit n = cog n running.
- `cog_req`  in  NUMCOGS  bit n = cog n requests hub access.
- `hub_phase`  out  1  0 = setup cycle, 1 = access cycle.
- `slot`  out  3  index of the cog owning the current hub cycle.
- `grant`  out  NUMCOGS  one-hot access grant, valid only in access cycles.
- `rot_start`  out  1  high during the setup cycle of slot 0.

## Operation
- **Registers:** `hub_phase`, `slot`, `grant`.
- **Reset values:** `hub_phase` = 0, `slot` = 0, `grant` = 0. `rot_start` = 1, because it is combinational from `slot` == 0 and `hub_phase` == 0.
- **Phase:** `hub_phase` toggles every clock.
- **Hub cycle:** one setup cycle followed by one access cycle (2 clocks).
- **Grant evaluation:** in a setup cycle (`hub_phase` = 0), on the clock edge, `grant` <= one-hot(`slot`) & `cog_req` & `cog_ena`. In an access cycle, `grant` <= 0. `grant` is therefore high only while `hub_phase` = 1, and at most one bit is ever set.
- **Slot advance:** at the end of an access cycle (`hub_phase` = 1 edge), `slot` <= next(`slot`). `slot` is constant across the setup/access pair.
- **Fixed mode (`SKIP_IDLE` = 0):** next = `slot` + 1, wrapping `NUMCOGS`-1 -> 0 (e.g. 2 -> 0 for `NUMCOGS` = 3). `cog_ena` does not affect the rotation.
- **Skip mode (`SKIP_IDLE` = 1):** next = (`slot` + k) mod `NUMCOGS` for the smallest k in 1..`NUMCOGS` with `cog_ena` set at that index. `cog_ena` is sampled in the access cycle.
  - Only the current cog enabled: k = `NUMCOGS`, so `slot` holds.
  - No cog enabled: `slot` + 1 with wrap, same as fixed mode.
- **Arithmetic:** the modulo is implemented by compare-and-subtract, not by bit truncation, so non-power-of-two `NUMCOGS` wraps correctly. `slot` upper bits above clog2(`NUMCOGS`) are 0.
- **Boundary conditions:**
  - A request deasserted during the access cycle does not retract an already-registered grant.
  - A request arriving after the owning setup cycle waits for the cog's next slot.
  - `cog_ena` dropped in the setup cycle suppresses that grant.
  - Simultaneous requests from all cogs: only the slot owner is granted; the others are not queued inside this block (each cog holds its request).
  - `inp_resn` low at any point clears all registers immediately, including mid-access with `grant` high. Release is synchronous to the next `clock_160` edge, and the first cycle after release is a setup cycle for slot 0.

## Timing
- **Grant latency:** a request present in the owner's setup cycle yields `grant` in the next cycle, for exactly 1 cycle.
- **Worst-case wait, fixed mode:** 2·`NUMCOGS` clocks from a missed setup cycle to the next grant (16 clocks at `NUMCOGS` = 8).
- **Worst-case wait, skip mode:** 2·(number of enabled cogs) clocks.
- **Reset release:** first `grant` possible at the 2nd clock after `inp_resn` rises.
- **`rot_start`:** period 2·`NUMCOGS` clocks in fixed mode.
- All outputs except `rot_start` are registered. `rot_start` passes through one comparator only.

## Test plan
- **Reset:** assert `inp_resn` = 0 mid-access with `grant` = 8'h04 -> `grant`, `slot` and `hub_phase` go to 0 without waiting for a clock edge. After release, the slot sequence is 0,0,1,1,2,2… per clock.
- **Fixed rotation:** `NUMCOGS` = 8, `SKIP_IDLE` = 0, `cog_req` = 8'hFF, `cog_ena` = 8'hFF -> `grant` = 01,00,02,00,04,…,80,00 repeating. `rot_start` pulses every 16 clocks.
- **Skip-idle:** `SKIP_IDLE` = 1, `cog_ena` = 8'b1000_0101, all requesting -> slot order 0,2,7,0. Grants 8'h01, 8'h04, 8'h80, one per 2 clocks.
- **Single / no enabled cog:** with skip mode and `cog_ena` = 8'h08, `slot` stays 3 and `grant` = 8'h08 every access cycle. With `cog_ena` = 0, `slot` increments 0..7 and `grant` stays 0.
- **Non-power-of-two wrap and late request:**
  - `NUMCOGS` = 3, fixed mode -> `slot` wraps 2 -> 0 and never reaches 3.
  - Cog 1 raises its request in its own access cycle -> no grant until slot 1 recurs, 6 clocks later.

Source files
------------

// File: rtl/hub_slot_scheduler.sv
// Hub time-slot scheduler: two-phase hub cycle, slot rotation (fixed or skip-idle)
// and one-hot grant issue to the cog owning the current slot.
module hub_slot_scheduler #(
   parameter int NUMCOGS   = 8,
   parameter bit SKIP_IDLE = 1'b0
) (
   input  logic               clock_160,
   input  logic               inp_resn,
   input  logic [NUMCOGS-1:0] cog_ena,
   input  logic [NUMCOGS-1:0] cog_req,
   output logic               hub_phase,
   output logic [2:0]         slot,
   output logic [NUMCOGS-1:0] grant,
   output logic               rot_start
);

   logic               phase_q, phase_d;
   logic [2:0]         slot_q, slot_d;
   logic [NUMCOGS-1:0] grant_q, grant_d;
   logic [NUMCOGS-1:0] onehot_s;
   logic [2:0]         next_slot_s;
   logic [2:0]         cand_s;
   logic               found_s;

   // Wrap by compare-and-subtract so non-power-of-two cog counts wrap correctly.
   function automatic logic [2:0] slot_add(input logic [2:0] base, input logic [3:0] step);
      logic [3:0] sum;
      sum = {1'b0, base} + step;
      if (sum >= 4'(NUMCOGS)) begin
         sum = sum - 4'(NUMCOGS);
      end else begin
         sum = sum;
      end
      return sum[2:0];
   endfunction

   function automatic logic ena_at(input logic [NUMCOGS-1:0] ena, input logic [2:0] idx);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < NUMCOGS; j++) begin
         if (idx == 3'(j)) begin
            hit = ena[j];
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   // Slot decode, next-slot selection and next-state for phase/slot/grant.
   always_comb begin
      phase_d     = ~phase_q;
      slot_d      = slot_q;
      grant_d     = '0;
      next_slot_s = slot_add(slot_q, 4'd1);
      cand_s      = 3'd0;
      found_s     = 1'b0;
      for (int j = 0; j < NUMCOGS; j++) begin
         onehot_s[j] = (slot_q == 3'(j));
      end
      if (SKIP_IDLE) begin
         // Smallest k wins; with nothing enabled the plain increment stays selected.
         for (int k = 1; k <= NUMCOGS; k++) begin
            cand_s = slot_add(slot_q, 4'(k));
            if (!found_s && ena_at(cog_ena, cand_s)) begin
               next_slot_s = cand_s;
               found_s     = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         next_slot_s = next_slot_s;
      end
      if (!phase_q) begin
         grant_d = onehot_s & cog_req & cog_ena;
      end else begin
         grant_d = '0;
         slot_d  = next_slot_s;
      end
   end

   // State registers, cleared immediately by reset.
   always_ff @(posedge clock_160 or negedge inp_resn) begin
      if (!inp_resn) begin
         phase_q <= 1'b0;
         slot_q  <= 3'd0;
         grant_q <= '0;
      end else begin
         phase_q <= phase_d;
         slot_q  <= slot_d;
         grant_q <= grant_d;
      end
   end

   assign hub_phase = phase_q;
   assign slot      = slot_q;
   assign grant     = grant_q;
   assign rot_start = (slot_q == 3'd0) && !phase_q;

endmodule

// File: tb/tb_hub_slot_scheduler.sv
// Self-checking bench: three scheduler instances (8 fixed, 8 skip-idle, 3 fixed)
// compared every clock against a slot-rule reference model.
module tb_hub_slot_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resn;
   logic [7:0] req, ena;

   logic       ph_a, ph_b, ph_c;
   logic [2:0] sl_a, sl_b, sl_c;
   logic [7:0] gr_a, gr_b;
   logic [2:0] gr_c;
   logic       rs_a, rs_b, rs_c;

   hub_slot_scheduler #(.NUMCOGS(8), .SKIP_IDLE(1'b0)) u_fix8 (
      .clock_160(clk), .inp_resn(resn), .cog_ena(ena), .cog_req(req),
      .hub_phase(ph_a), .slot(sl_a), .grant(gr_a), .rot_start(rs_a));

   hub_slot_scheduler #(.NUMCOGS(8), .SKIP_IDLE(1'b1)) u_skip8 (
      .clock_160(clk), .inp_resn(resn), .cog_ena(ena), .cog_req(req),
      .hub_phase(ph_b), .slot(sl_b), .grant(gr_b), .rot_start(rs_b));

   hub_slot_scheduler #(.NUMCOGS(3), .SKIP_IDLE(1'b0)) u_fix3 (
      .clock_160(clk), .inp_resn(resn), .cog_ena(ena[2:0]), .cog_req(req[2:0]),
      .hub_phase(ph_c), .slot(sl_c), .grant(gr_c), .rot_start(rs_c));

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   int ncog[3] = '{8, 8, 3};
   bit skp[3]  = '{1'b0, 1'b1, 1'b0};
   int m_slot[3];
   int m_phase[3];
   int m_grant[3];

   function automatic int next_slot(int i, int s, logic [7:0] e);
      for (int k = 1; k <= ncog[i]; k++) begin
         if (skp[i] && e[(s + k) % ncog[i]]) return (s + k) % ncog[i];
      end
      return (s + 1) % ncog[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_slot[i] = 0; m_phase[i] = 0; m_grant[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (m_phase[i] == 0) begin
            m_grant[i] = (req[m_slot[i]] && ena[m_slot[i]]) ? (1 << m_slot[i]) : 0;
         end else begin
            m_grant[i] = 0;
            m_slot[i]  = next_slot(i, m_slot[i], ena);
         end
         m_phase[i] = 1 - m_phase[i];
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [31:0] o_sl[3], o_ph[3], o_gr[3], o_rs[3];
      o_sl = '{32'(sl_a), 32'(sl_b), 32'(sl_c)};
      o_ph = '{32'(ph_a), 32'(ph_b), 32'(ph_c)};
      o_gr = '{32'(gr_a), 32'(gr_b), 32'(gr_c)};
      o_rs = '{32'(rs_a), 32'(rs_b), 32'(rs_c)};
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_u%0d_slot", tag, i),  o_sl[i], 32'(m_slot[i]));
         check($sformatf("%s_u%0d_phase", tag, i), o_ph[i], 32'(m_phase[i]));
         check($sformatf("%s_u%0d_grant", tag, i), o_gr[i], 32'(m_grant[i]));
         check($sformatf("%s_u%0d_rot", tag, i),   o_rs[i],
               32'((m_slot[i] == 0 && m_phase[i] == 0) ? 1 : 0));
      end
   endtask

   task automatic cyc(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      int rs_cnt;
      int max_c;
      int lat;
      bit found;

      resn = 1'b1; req = 8'h00; ena = 8'h00;
      #2 resn = 1'b0;
      model_reset();
      #1 check_all("reset");
      @(posedge clk); #1 check_all("reset_hold");
      resn = 1'b1;

      // Fixed rotation with everyone requesting; reset asserted mid-access on slot 2.
      req = 8'hFF; ena = 8'hFF;
      for (int t = 0; t < 5; t++) cyc("fixed_pre");
      check("pre_reset_grant", 32'(gr_a), 32'h04);
      resn = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      check("async_reset_grant", 32'(gr_a), 32'h00);
      #1 resn = 1'b1;

      rs_cnt = 0;
      for (int t = 0; t < 32; t++) begin
         cyc("fixed_all");
         if (rs_a) rs_cnt++;
      end
      check("rot_start_per_32", 32'(rs_cnt), 32'd2);

      // Skip-idle with cogs 0, 2, 7 running.
      ena = 8'b1000_0101;
      for (int t = 0; t < 16; t++) cyc("skip_three");

      // Only cog 3 running: skip mode parks on slot 3.
      ena = 8'h08;
      for (int t = 0; t < 10; t++) cyc("skip_single");
      check("skip_single_slot", 32'(sl_b), 32'd3);

      // Nothing running: plain increment, no grants.
      ena = 8'h00;
      for (int t = 0; t < 16; t++) cyc("skip_none");

      // Late request on the 3-cog instance: raised during slot 1's access cycle.
      req = 8'h00; ena = 8'hFF;
      found = 1'b0;
      for (int t = 0; t < 12 && !found; t++) begin
         cyc("late_seek");
         if (sl_c == 3'd1 && ph_c == 1'b1) found = 1'b1;
      end
      check("late_seek_found", 32'(found), 32'd1);
      req = 8'h02;
      lat = -1;
      for (int t = 1; t <= 10; t++) begin
         cyc("late_wait");
         if (lat < 0 && gr_c == 3'b010) lat = t;
      end
      check("late_req_latency", 32'(lat), 32'd6);

      // Randomized inputs, including requests dropped during access cycles.
      max_c = 0;
      for (int t = 0; t < 300; t++) begin
         req = 8'($urandom);
         ena = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
         cyc("random");
         if (int'(sl_c) > max_c) max_c = int'(sl_c);
      end
      check("fix3_max_slot", 32'(max_c), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
